// File: rtl/wisecore_defs.sv
// Shared definitions for the execute stage: op classes, op codes,
// divider state encoding and small arithmetic helpers.
package wisecore_defs;

    localparam int DATA_W     = 32;
    localparam int DIV_CYCLES = 32;

    // Op classes carried on alusel
    localparam logic [2:0] ALUSEL_NOP   = 3'b000;
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [2:0] ALUSEL_DIV   = 3'b011;
    localparam logic [2:0] ALUSEL_ARITH = 3'b100;

    // Op codes carried on aluop
    localparam logic [7:0] EXE_OR_OP   = 8'h25;
    localparam logic [7:0] EXE_AND_OP  = 8'h24;
    localparam logic [7:0] EXE_XOR_OP  = 8'h26;
    localparam logic [7:0] EXE_NOR_OP  = 8'h27;
    localparam logic [7:0] EXE_SLL_OP  = 8'h7C;
    localparam logic [7:0] EXE_SRL_OP  = 8'h02;
    localparam logic [7:0] EXE_SRA_OP  = 8'h03;
    localparam logic [7:0] EXE_ADDU_OP = 8'h21;
    localparam logic [7:0] EXE_SUBU_OP = 8'h23;
    localparam logic [7:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [7:0] EXE_SLTU_OP = 8'h2B;
    localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Two's-complement negation
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of v when treated as signed, otherwise v unchanged
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand bundle into the execute stage and its EX/MEM results.
interface ex_stage_if;
    logic [2:0]  i_alusel;
    logic [7:0]  i_aluop;
    logic [31:0] i_reg1_data;
    logic [31:0] i_reg2_data;
    logic        i_wreg;
    logic [4:0]  i_wreg_addr;
    logic        i_annul;
    logic        o_wreg;
    logic [4:0]  o_wreg_addr;
    logic [31:0] o_wdata;
    logic        o_whilo;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_stallreq;

    // Pipeline side that issues operands and consumes results
    modport master (
        output i_alusel, i_aluop, i_reg1_data, i_reg2_data, i_wreg, i_wreg_addr, i_annul,
        input  o_wreg, o_wreg_addr, o_wdata, o_whilo, o_hi, o_lo, o_stallreq
    );

    // Execute stage side
    modport slave (
        input  i_alusel, i_aluop, i_reg1_data, i_reg2_data, i_wreg, i_wreg_addr, i_annul,
        output o_wreg, o_wreg_addr, o_wdata, o_whilo, o_hi, o_lo, o_stallreq
    );
endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on
// operand magnitudes, sign fix-up and divide-by-zero override at the output.
module div_unit
    import wisecore_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        annul,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_r;
    div_state_e  next_s;
    logic [31:0] quo_r;      // dividend shifting out, quotient shifting in
    logic [31:0] rem_r;      // partial remainder
    logic [31:0] dsr_r;      // divisor magnitude
    logic [31:0] raw_a_r;    // untouched dividend for the divide-by-zero result
    logic [5:0]  cnt_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        dz_r;

    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        busy_s;
    logic        done_s;

    // One restoring step: bring in the next dividend bit and trial-subtract
    always_comb begin
        shifted_s = {rem_r, quo_r[31]};
        diff_s    = shifted_s - {1'b0, dsr_r};
    end

    // Next-state and status decode; annul always wins and returns to IDLE
    always_comb begin
        next_s = state_r;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            DIV_IDLE: begin
                busy_s = start;
                if (start) begin
                    next_s = DIV_BUSY;
                end else begin
                    next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                busy_s = 1'b1;
                if (cnt_r == 6'(DIV_CYCLES - 1)) begin
                    next_s = DIV_DONE;
                end else begin
                    next_s = DIV_BUSY;
                end
            end
            DIV_DONE: begin
                done_s = 1'b1;
                next_s = DIV_IDLE;
            end
            default: begin
                next_s = DIV_IDLE;
            end
        endcase
        if (annul) begin
            next_s = DIV_IDLE;
            busy_s = 1'b0;
            done_s = 1'b0;
        end else begin
            next_s = next_s;
        end
    end

    // State register plus operand capture and per-cycle iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DIV_IDLE;
            quo_r   <= 32'd0;
            rem_r   <= 32'd0;
            dsr_r   <= 32'd0;
            raw_a_r <= 32'd0;
            cnt_r   <= 6'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= next_s;
            case (state_r)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        quo_r   <= mag32(a, sign_en);
                        rem_r   <= 32'd0;
                        dsr_r   <= mag32(b, sign_en);
                        raw_a_r <= a;
                        cnt_r   <= 6'd0;
                        neg_q_r <= sign_en & (a[31] ^ b[31]);
                        neg_r_r <= sign_en & a[31];
                        dz_r    <= (b == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    if (!annul) begin
                        cnt_r <= cnt_r + 6'd1;
                        if (diff_s[32]) begin
                            rem_r <= shifted_s[31:0];
                            quo_r <= {quo_r[30:0], 1'b0};
                        end else begin
                            rem_r <= diff_s[31:0];
                            quo_r <= {quo_r[30:0], 1'b1};
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy      = busy_s;
    assign done      = done_s;
    assign quotient  = dz_r ? 32'hFFFF_FFFF : (neg_q_r ? neg32(quo_r) : quo_r);
    assign remainder = dz_r ? raw_a_r : (neg_r_r ? neg32(rem_r) : rem_r);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ALU, result muxing to
// EX/MEM, and the iterative divider driving HI/LO and the upstream stall.
module ex_stage
    import wisecore_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);

    logic [31:0] alu_res_s;
    logic        div_class_s;
    logic        div_start_s;
    logic        div_signed_s;
    logic        div_busy_s;
    logic        div_done_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;
    logic [4:0]  sh_s;

    assign sh_s         = bus.i_reg2_data[4:0];
    assign div_class_s  = (bus.i_alusel == ALUSEL_DIV);
    assign div_signed_s = (bus.i_aluop == EXE_DIV_OP);
    assign div_start_s  = div_class_s && !rst &&
                          ((bus.i_aluop == EXE_DIV_OP) || (bus.i_aluop == EXE_DIVU_OP));

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .sign_en   (div_signed_s),
        .a         (bus.i_reg1_data),
        .b         (bus.i_reg2_data),
        .annul     (bus.i_annul),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Single-cycle ALU; unknown class or op yields zero
    always_comb begin
        alu_res_s = 32'd0;
        case (bus.i_alusel)
            ALUSEL_LOGIC: begin
                case (bus.i_aluop)
                    EXE_OR_OP:  alu_res_s = bus.i_reg1_data | bus.i_reg2_data;
                    EXE_AND_OP: alu_res_s = bus.i_reg1_data & bus.i_reg2_data;
                    EXE_XOR_OP: alu_res_s = bus.i_reg1_data ^ bus.i_reg2_data;
                    EXE_NOR_OP: alu_res_s = ~(bus.i_reg1_data | bus.i_reg2_data);
                    default:    alu_res_s = 32'd0;
                endcase
            end
            ALUSEL_SHIFT: begin
                case (bus.i_aluop)
                    EXE_SLL_OP: alu_res_s = bus.i_reg1_data << sh_s;
                    EXE_SRL_OP: alu_res_s = bus.i_reg1_data >> sh_s;
                    EXE_SRA_OP: alu_res_s = $unsigned($signed(bus.i_reg1_data) >>> sh_s);
                    default:    alu_res_s = 32'd0;
                endcase
            end
            ALUSEL_ARITH: begin
                case (bus.i_aluop)
                    EXE_ADDU_OP: alu_res_s = bus.i_reg1_data + bus.i_reg2_data;
                    EXE_SUBU_OP: alu_res_s = bus.i_reg1_data - bus.i_reg2_data;
                    EXE_SLT_OP:  alu_res_s = {31'd0, ($signed(bus.i_reg1_data) < $signed(bus.i_reg2_data))};
                    EXE_SLTU_OP: alu_res_s = {31'd0, (bus.i_reg1_data < bus.i_reg2_data)};
                    default:     alu_res_s = 32'd0;
                endcase
            end
            default: begin
                alu_res_s = 32'd0;
            end
        endcase
    end

    // Output mux; everything is held at zero while reset is asserted
    always_comb begin
        bus.o_wreg      = 1'b0;
        bus.o_wreg_addr = 5'd0;
        bus.o_wdata     = 32'd0;
        bus.o_whilo     = 1'b0;
        bus.o_hi        = 32'd0;
        bus.o_lo        = 32'd0;
        bus.o_stallreq  = 1'b0;
        if (rst) begin
            bus.o_wreg = 1'b0;
        end else begin
            bus.o_wreg_addr = bus.i_wreg_addr;
            bus.o_stallreq  = div_busy_s;
            bus.o_whilo     = div_done_s;
            if (div_done_s) begin
                bus.o_hi = div_rem_s;
                bus.o_lo = div_quo_s;
            end else begin
                bus.o_hi = 32'd0;
                bus.o_lo = 32'd0;
            end
            if (div_class_s) begin
                bus.o_wreg  = 1'b0;
                bus.o_wdata = 32'd0;
            end else begin
                bus.o_wreg  = bus.i_wreg;
                bus.o_wdata = alu_res_s;
            end
        end
    end

endmodule
